// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs one outstanding req/gnt/rvalid fetch, hands words to the decoder.
// Optional IFU_EBREAK_HALT_EN: stop fetching after an ebreak has been delivered (adds the halted port).
module inst_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc
`ifdef IFU_EBREAK_HALT_EN
    ,
    output logic            halted
`endif
);

`ifdef IFU_EBREAK_HALT_EN
    localparam logic [31:0] EBREAK = 32'h0010_0073;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
`ifdef IFU_EBREAK_HALT_EN
        ,
        S_HALT
`endif
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            drop;
    logic [XLEN-1:0] redirect_tgt;
    logic [XLEN-1:0] pc_plus4;
    logic            unused_redirect_lsbs;

    assign redirect_tgt         = {redirect_pc[XLEN-1:2], 2'b00};
    assign pc_plus4             = pc + XLEN'(4);
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A redirect while a request is pending keeps the old address on the bus;
    // the drop flag then discards the response belonging to that request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= 32'h0;
            inst_pc    <= RESET_PC;
            drop       <= 1'b0;
`ifdef IFU_EBREAK_HALT_EN
            halted     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    imem_req <= 1'b1;
                    state    <= S_REQ;
                    if (redirect_valid) begin
                        pc        <= redirect_tgt;
                        imem_addr <= redirect_tgt;
                    end else begin
                        imem_addr <= pc;
                    end
                end

                S_REQ: begin
                    if (redirect_valid) begin
                        pc   <= redirect_tgt;
                        drop <= 1'b1;
                    end
                    if (imem_gnt) begin
                        imem_req <= 1'b0;
                        state    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop || redirect_valid) begin
                            drop     <= 1'b0;
                            imem_req <= 1'b1;
                            state    <= S_REQ;
                            if (redirect_valid) begin
                                pc        <= redirect_tgt;
                                imem_addr <= redirect_tgt;
                            end else begin
                                imem_addr <= pc;
                            end
                        end else begin
                            inst       <= imem_rdata;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        pc   <= redirect_tgt;
                        drop <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (redirect_valid) begin
                        // Handshake (if any) still completes; the new target replaces pc+4.
                        pc         <= redirect_tgt;
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        imem_addr  <= redirect_tgt;
                        state      <= S_REQ;
                    end else if (inst_ready) begin
                        inst_valid <= 1'b0;
                        pc         <= pc_plus4;
`ifdef IFU_EBREAK_HALT_EN
                        if (inst == EBREAK) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= pc_plus4;
                            state     <= S_REQ;
                        end
`else
                        imem_req  <= 1'b1;
                        imem_addr <= pc_plus4;
                        state     <= S_REQ;
`endif
                    end
                end

`ifdef IFU_EBREAK_HALT_EN
                S_HALT: begin
                    imem_req <= 1'b0;
                end
`endif

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder: owns the PC, fetches one 32-bit instruction per request over a req/gnt/rvalid memory port, and presents it to the decoder with a valid/ready handshake.
- Accepts PC redirects from execute (jal/jalr/branch) and discards stale in-flight responses.
- At most one memory request outstanding.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address; stable while imem_req=1 and no grant
- imem_gnt  in  1  request accepted this cycle (imem_req & imem_gnt)
- imem_rvalid  in  1  response valid; earliest one cycle after grant
- imem_rdata  in  32  instruction word, sampled when imem_rvalid=1
- redirect_valid  in  1  PC redirect strobe, one cycle
- redirect_pc  in  XLEN  redirect target; bits[1:0] forced to 0
- inst_valid  out  1  inst/inst_pc valid to decoder
- inst_ready  in  1  decoder accepts
- inst  out  32  fetched instruction
- inst_pc  out  XLEN  PC of inst
- halted  out  1  fetch halted; exists only with IFU_EBREAK_HALT_EN

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=32'h0, inst_pc=RESET_PC, drop flag=0, halted=0.
- States:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req=1, imem_addr=pc. On imem_gnt go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid: if drop=0, latch inst=imem_rdata, inst_pc=pc, set inst_valid, go to HOLD. If drop=1, clear drop and go to REQ.
  - HOLD: inst_valid=1, inst/inst_pc held stable. On inst_valid & inst_ready, pc <= pc+4, inst_valid <= 0, go to REQ.
- PC arithmetic: modulo 2^XLEN; 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Redirect (any state, highest priority):
  - pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - IDLE: pc updates; state proceeds to REQ as normal.
  - HOLD: inst_valid <= 0 next cycle, go to REQ.
  - REQ without grant: address stays old while req is pending. On its grant, drop=1. Alternatively the redirect is applied before the grant, at implementer's choice: address may change only when req is low; here it is pending, so the grant drops the response.
  - REQ with grant same cycle: drop=1, go to WAIT.
  - WAIT: drop=1. If rvalid arrives the same cycle, that response is discarded; go to REQ.
  - Redirect together with inst_valid & inst_ready: the handshake completes (decoder owns the word), and pc takes redirect_pc, not pc+4.
- Latency: minimum 3 cycles per instruction (REQ with gnt, WAIT with rvalid, HOLD with ready). First inst_valid at earliest 3 cycles after reset release.
- imem_rvalid in IDLE/REQ/HOLD is a protocol error, ignored.
- Reset mid-operation clears everything immediately, including drop. A later stray rvalid is ignored per the rule above.

Optional Feature:
- Macro IFU_EBREAK_HALT_EN.
- Defined:
  - When a latched, non-dropped instruction equals 32'h0010_0073 (ebreak), it is delivered normally.
  - After its handshake, the unit enters HALT instead of REQ: imem_req=0, halted=1, and no further fetches.
  - Only rst leaves HALT; redirects are ignored while halted.
- Undefined: ebreak is fetched like any other word, the halted port is absent, and there is no HALT state.

Test Plan:
- Reset then memory with gnt=1 and rvalid one cycle later, ready=1 -> addresses 8000_0000, 8000_0004, 8000_0008, one instruction every 3 cycles; inst_pc matches each address.
- Decoder backpressure: ready=0 for 5 cycles with inst=32'h0010_0093 -> inst/inst_pc stable, imem_req=0 throughout; after ready, next address is +4.
- Redirect to 8000_0100 while in WAIT, rvalid 2 cycles later with 32'hDEAD_BEEF -> word never appears on inst; next imem_addr=8000_0100.
- Grant withheld 4 cycles at 8000_0010 with redirect in cycle 2 -> imem_addr holds 8000_0010 until grant, response dropped, next request 8000_0200 (redirect_pc=8000_0203 gives aligned 8000_0200).
- Wrap: redirect to FFFF_FFFC, complete fetch -> next address 0000_0000.
- IFU_EBREAK_HALT_EN: fetch 32'h0010_0073 at 8000_0008 -> delivered, then halted=1 and imem_req stays 0 for 20 cycles despite a redirect. Async rst returns to RESET_PC fetch.
